// File: rtl/ps2_bus_controller.sv
// PS/2 keyboard bus sequencer: receives device scan-code frames and sends host commands
// over the open-drain clock/data pair, with receive priority and per-phase timeouts.
module ps2_bus_controller #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned BIT_TIMEOUT    = 100000,
   parameter int unsigned REQ_TIMEOUT    = 1000000
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic       PS2_KBCLK,
   input  logic       PS2_KBDAT,
   output logic       PS2_KBCLK_OE,
   output logic       PS2_KBDAT_OE,
   input  logic       CMD_VALID,
   input  logic [7:0] CMD_DATA,
   output logic       CMD_READY,
   output logic       CMD_DONE,
   output logic       CMD_ACKED,
   output logic       RX_VALID,
   output logic [7:0] RX_DATA,
   output logic       RX_ERR,
   output logic       BUSY
);

   localparam int unsigned MAX_A = (REQ_TIMEOUT > BIT_TIMEOUT) ? REQ_TIMEOUT : BIT_TIMEOUT;
   localparam int unsigned MAX_T = (MAX_A > INHIBIT_CYCLES) ? MAX_A : INHIBIT_CYCLES;
   localparam int unsigned CNT_W = $clog2(MAX_T + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX,
      S_INHIBIT,
      S_REQ,
      S_TX,
      S_TX_ACK
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       kbclk_sync_q, kbclk_sync_d;
   logic [1:0]       kbdat_sync_q, kbdat_sync_d;
   logic             kbclk_prev_q, kbclk_prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [9:0]       rx_shift_q, rx_shift_d;
   logic [8:0]       tx_bits_q, tx_bits_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_err_q, rx_err_d;
   logic             cmd_done_q, cmd_done_d;
   logic             cmd_acked_q, cmd_acked_d;
   logic [7:0]       rx_data_q, rx_data_d;

   logic             fall;
   logic             dat_s;
   logic [10:0]      frame;
   logic             frame_ok;

   assign fall     = kbclk_prev_q & ~kbclk_sync_q[1];
   assign dat_s    = kbdat_sync_q[1];
   assign frame    = {dat_s, rx_shift_q};
   assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

   always_comb begin
      kbclk_sync_d = {kbclk_sync_q[0], PS2_KBCLK};
      kbdat_sync_d = {kbdat_sync_q[0], PS2_KBDAT};
      kbclk_prev_d = kbclk_sync_q[1];
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      rx_shift_d   = rx_shift_q;
      tx_bits_d    = tx_bits_q;
      clk_oe_d     = clk_oe_q;
      dat_oe_d     = dat_oe_q;
      rx_valid_d   = 1'b0;
      rx_err_d     = 1'b0;
      cmd_done_d   = 1'b0;
      cmd_acked_d  = cmd_acked_q;
      rx_data_d    = rx_data_q;

      case (state_q)
         S_IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (fall) begin
               state_d    = S_RX;
               rx_shift_d = {dat_s, rx_shift_q[9:1]};
               bit_cnt_d  = 4'd1;
            end else if (CMD_VALID) begin
               state_d   = S_INHIBIT;
               tx_bits_d = {~^CMD_DATA, CMD_DATA};
               clk_oe_d  = 1'b1;
            end
         end
         S_RX: begin
            if (fall) begin
               if (bit_cnt_q == 4'd10) begin
                  state_d   = S_IDLE;
                  bit_cnt_d = 4'd0;
                  if (frame_ok) begin
                     rx_valid_d = 1'b1;
                     rx_data_d  = frame[8:1];
                  end else begin
                     rx_err_d = 1'b1;
                  end
               end else begin
                  rx_shift_d = {dat_s, rx_shift_q[9:1]};
                  bit_cnt_d  = bit_cnt_q + 4'd1;
               end
            end else if (cnt_q == CNT_W'(BIT_TIMEOUT - 1)) begin
               state_d   = S_IDLE;
               bit_cnt_d = 4'd0;
               rx_err_d  = 1'b1;
            end
         end
         S_INHIBIT: begin
            if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
               state_d  = S_REQ;
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b1;
            end
         end
         S_REQ: begin
            // The device's first falling edge already asks for data bit 0.
            if (fall) begin
               state_d   = S_TX;
               dat_oe_d  = ~tx_bits_q[0];
               bit_cnt_d = 4'd1;
            end else if (cnt_q == CNT_W'(REQ_TIMEOUT - 1)) begin
               state_d    = S_IDLE;
               clk_oe_d   = 1'b0;
               dat_oe_d   = 1'b0;
               cmd_done_d = 1'b1;
               cmd_acked_d = 1'b0;
            end
         end
         S_TX: begin
            if (fall) begin
               if (bit_cnt_q == 4'd9) begin
                  state_d   = S_TX_ACK;
                  dat_oe_d  = 1'b0;
                  bit_cnt_d = 4'd0;
               end else begin
                  dat_oe_d  = ~tx_bits_q[bit_cnt_q];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else if (cnt_q == CNT_W'(BIT_TIMEOUT - 1)) begin
               state_d     = S_IDLE;
               bit_cnt_d   = 4'd0;
               clk_oe_d    = 1'b0;
               dat_oe_d    = 1'b0;
               cmd_done_d  = 1'b1;
               cmd_acked_d = 1'b0;
            end
         end
         S_TX_ACK: begin
            if (fall) begin
               state_d     = S_IDLE;
               cmd_done_d  = 1'b1;
               cmd_acked_d = ~dat_s;
            end else if (cnt_q == CNT_W'(BIT_TIMEOUT - 1)) begin
               state_d     = S_IDLE;
               clk_oe_d    = 1'b0;
               dat_oe_d    = 1'b0;
               cmd_done_d  = 1'b1;
               cmd_acked_d = 1'b0;
            end
         end
         default: begin
            state_d  = S_IDLE;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
         end
      endcase

      // Our own clock pull-down during INHIBIT looks like a fall, so it must not restart that count.
      if ((state_d != state_q) || (state_q == S_IDLE) || (fall && (state_q != S_INHIBIT))) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= S_IDLE;
         kbclk_sync_q <= 2'b11;
         kbdat_sync_q <= 2'b11;
         kbclk_prev_q <= 1'b1;
         cnt_q        <= '0;
         bit_cnt_q    <= 4'd0;
         rx_shift_q   <= 10'd0;
         tx_bits_q    <= 9'd0;
         clk_oe_q     <= 1'b0;
         dat_oe_q     <= 1'b0;
         rx_valid_q   <= 1'b0;
         rx_err_q     <= 1'b0;
         cmd_done_q   <= 1'b0;
         cmd_acked_q  <= 1'b0;
         rx_data_q    <= 8'h00;
      end else begin
         state_q      <= state_d;
         kbclk_sync_q <= kbclk_sync_d;
         kbdat_sync_q <= kbdat_sync_d;
         kbclk_prev_q <= kbclk_prev_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_shift_q   <= rx_shift_d;
         tx_bits_q    <= tx_bits_d;
         clk_oe_q     <= clk_oe_d;
         dat_oe_q     <= dat_oe_d;
         rx_valid_q   <= rx_valid_d;
         rx_err_q     <= rx_err_d;
         cmd_done_q   <= cmd_done_d;
         cmd_acked_q  <= cmd_acked_d;
         rx_data_q    <= rx_data_d;
      end
   end

   assign PS2_KBCLK_OE = clk_oe_q;
   assign PS2_KBDAT_OE = dat_oe_q;
   assign CMD_READY    = (state_q == S_IDLE) & ~fall;
   assign CMD_DONE     = cmd_done_q;
   assign CMD_ACKED    = cmd_acked_q;
   assign RX_VALID     = rx_valid_q;
   assign RX_DATA      = rx_data_q;
   assign RX_ERR       = rx_err_q;
   assign BUSY         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_bus_controller.sv
// Self-checking bench for ps2_bus_controller: a PS/2 device model drives frames and
// services host commands while a scoreboard matches RX_VALID/RX_ERR/CMD_DONE events.
module tb_ps2_bus_controller;

   localparam int INH = 20;
   localparam int BT  = 200;
   localparam int RT  = 400;
   localparam int H   = 20;
   localparam int K_RX_OK  = 0;
   localparam int K_RX_ERR = 1;
   localparam int K_CMD    = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } exp_t;

   logic       clock_50 = 1'b0;
   logic       reset_n = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       ps2_kbclk, ps2_kbdat;
   logic       kbclk_oe, kbdat_oe;
   logic       cmd_ready, cmd_done, cmd_acked;
   logic       rx_valid, rx_err, busy;
   logic [7:0] rx_data;

   int         compared = 0;
   int         mismatched = 0;
   exp_t       sb[$];
   exp_t       mon_e;
   int         mon_kind;
   logic [7:0] mon_val;
   logic [10:0] cap;
   int         n;
   bit         rx_seen;
   bit         acc_done;
   int         w;

   assign ps2_kbclk = dev_clk & ~kbclk_oe;
   assign ps2_kbdat = dev_dat & ~kbdat_oe;

   ps2_bus_controller #(
      .INHIBIT_CYCLES(INH),
      .BIT_TIMEOUT   (BT),
      .REQ_TIMEOUT   (RT)
   ) dut (
      .CLOCK_50    (clock_50),
      .RESET_N     (reset_n),
      .PS2_KBCLK   (ps2_kbclk),
      .PS2_KBDAT   (ps2_kbdat),
      .PS2_KBCLK_OE(kbclk_oe),
      .PS2_KBDAT_OE(kbdat_oe),
      .CMD_VALID   (cmd_valid),
      .CMD_DATA    (cmd_data),
      .CMD_READY   (cmd_ready),
      .CMD_DONE    (cmd_done),
      .CMD_ACKED   (cmd_acked),
      .RX_VALID    (rx_valid),
      .RX_DATA     (rx_data),
      .RX_ERR      (rx_err),
      .BUSY        (busy)
   );

   always #5 clock_50 = ~clock_50;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rx_frame(input logic [7:0] d, input logic flip, input int nbits, input logic collide);
      logic [10:0] f;
      f = {1'b1, (~^d) ^ flip, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         dev_dat = f[i];
         repeat (H) @(negedge clock_50);
         dev_clk = 1'b0;
         if (collide && i == 0) begin
            @(negedge clock_50);
            @(negedge clock_50);
            cmd_valid = 1'b1;
            cmd_data  = 8'h3A;
            check_output("collide_ready", cmd_ready, 0);
            repeat (H - 2) @(negedge clock_50);
         end else begin
            repeat (H) @(negedge clock_50);
         end
         dev_clk = 1'b1;
      end
      dev_dat = 1'b1;
   endtask

   task automatic send_cmd(input logic [7:0] d);
      int cnt;
      @(negedge clock_50);
      cmd_valid = 1'b1;
      cmd_data  = d;
      check_output("cmd_ready", cmd_ready, 1);
      @(negedge clock_50);
      cmd_valid = 1'b0;
      check_output("busy_after_accept", busy, 1);
      cnt = 0;
      while (kbclk_oe === 1'b1 && cnt < INH + 50) begin
         cnt++;
         @(negedge clock_50);
      end
      check_output("inhibit_len", cnt, INH);
      check_output("start_bit_oe", kbdat_oe, 1);
   endtask

   task automatic tx_device(input logic ack, input int npulse, output logic [10:0] c);
      int cnt;
      cnt = 0;
      c = '1;
      while (!(ps2_kbclk === 1'b1 && ps2_kbdat === 1'b0) && cnt < 100) begin
         @(negedge clock_50);
         cnt++;
      end
      check_output("req_seen", ps2_kbdat, 0);
      c[0] = ps2_kbdat;
      for (int i = 1; i <= npulse; i++) begin
         repeat (H) @(negedge clock_50);
         dev_clk = 1'b0;
         repeat (H) @(negedge clock_50);
         dev_clk = 1'b1;
         c[i] = ps2_kbdat;
      end
      if (npulse == 10) begin
         repeat (H / 2) @(negedge clock_50);
         dev_dat = ack;
         repeat (H / 2) @(negedge clock_50);
         dev_clk = 1'b0;
         repeat (H) @(negedge clock_50);
         dev_clk = 1'b1;
         dev_dat = 1'b1;
      end
   endtask

   task automatic wait_drain(input int limit, output int cnt);
      cnt = 0;
      while (sb.size() != 0 && cnt < limit) begin
         @(negedge clock_50);
         cnt++;
      end
      check_output("drain", sb.size(), 0);
   endtask

   // Every completion pulse must match the next expected event, and is high for one cycle only.
   always @(negedge clock_50) begin
      if (reset_n && (rx_valid || rx_err || cmd_done)) begin
         mon_kind = rx_valid ? K_RX_OK : (rx_err ? K_RX_ERR : K_CMD);
         mon_val  = (mon_kind == K_CMD) ? {7'd0, cmd_acked} : rx_data;
         if (sb.size() == 0) begin
            check_output("unexpected_event", mon_kind, 32'hFFFF_FFFF);
         end else begin
            mon_e = sb.pop_front();
            check_output("event_kind", mon_kind, mon_e.kind);
            check_output("event_data", mon_val, mon_e.data);
            if (mon_kind == K_CMD) begin
               check_output("done_clk_oe", kbclk_oe, 0);
               check_output("done_dat_oe", kbdat_oe, 0);
            end
         end
      end
   end

   initial begin
      #200_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #12;
      check_output("rst_busy", busy, 0);
      check_output("rst_clk_oe", kbclk_oe, 0);
      check_output("rst_dat_oe", kbdat_oe, 0);
      check_output("rst_rx_valid", rx_valid, 0);
      check_output("rst_rx_err", rx_err, 0);
      check_output("rst_cmd_done", cmd_done, 0);
      check_output("rst_cmd_acked", cmd_acked, 0);
      check_output("rst_rx_data", rx_data, 8'h00);
      @(negedge clock_50);
      reset_n = 1'b1;
      @(negedge clock_50);
      check_output("rst_cmd_ready", cmd_ready, 1);

      sb.push_back('{K_RX_OK, 8'h1C});
      rx_frame(8'h1C, 1'b0, 11, 1'b0);
      wait_drain(100, n);
      check_output("rx_busy_after", busy, 0);

      sb.push_back('{K_RX_ERR, 8'h1C});
      rx_frame(8'h1C, 1'b1, 11, 1'b0);
      wait_drain(100, n);

      sb.push_back('{K_RX_ERR, 8'h1C});
      rx_frame(8'h1C, 1'b0, 5, 1'b0);
      wait_drain(BT + 50, n);
      check_output("rx_timeout_time", (n >= BT - 40) && (n <= BT), 1);
      check_output("rx_timeout_idle", busy, 0);

      sb.push_back('{K_RX_OK, 8'h29});
      rx_frame(8'h29, 1'b0, 11, 1'b0);
      wait_drain(100, n);

      sb.push_back('{K_CMD, 8'h01});
      send_cmd(8'hED);
      tx_device(1'b0, 10, cap);
      check_output("tx_ed_start", cap[0], 0);
      check_output("tx_ed_data", cap[8:1], 8'hED);
      check_output("tx_ed_parity", cap[9], 1);
      check_output("tx_ed_stop", cap[10], 1);
      wait_drain(100, n);
      check_output("tx_busy_after", busy, 0);

      sb.push_back('{K_CMD, 8'h00});
      send_cmd(8'h07);
      tx_device(1'b1, 10, cap);
      check_output("tx_07_data", cap[8:1], 8'h07);
      check_output("tx_07_parity", cap[9], 0);
      wait_drain(100, n);

      sb.push_back('{K_CMD, 8'h00});
      send_cmd(8'h55);
      wait_drain(RT + 50, n);
      check_output("req_timeout_time", (n >= RT - 5) && (n <= RT + 5), 1);

      sb.push_back('{K_RX_OK, 8'h75});
      sb.push_back('{K_CMD, 8'h01});
      rx_seen  = 1'b0;
      acc_done = 1'b0;
      w = 0;
      fork
         rx_frame(8'h75, 1'b0, 11, 1'b1);
         begin
            while (!acc_done && w < 40 * H) begin
               @(negedge clock_50);
               w++;
               if (rx_valid) rx_seen = 1'b1;
               if (cmd_valid && cmd_ready) begin
                  check_output("accept_after_rx", rx_seen, 1);
                  acc_done = 1'b1;
               end
            end
            check_output("accept_seen", acc_done, 1);
            @(negedge clock_50);
            cmd_valid = 1'b0;
            check_output("collide_inhibit", kbclk_oe, 1);
         end
      join
      tx_device(1'b0, 10, cap);
      check_output("tx_3a_data", cap[8:1], 8'h3A);
      wait_drain(100, n);

      send_cmd(8'hA5);
      tx_device(1'b0, 5, cap);
      repeat (3) @(negedge clock_50);
      check_output("mid_tx_busy", busy, 1);
      check_output("mid_tx_bit4_oe", kbdat_oe, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_output("async_rst_clk_oe", kbclk_oe, 0);
      check_output("async_rst_dat_oe", kbdat_oe, 0);
      check_output("async_rst_busy", busy, 0);
      @(negedge clock_50);
      reset_n = 1'b1;
      @(negedge clock_50);
      check_output("post_rst_busy", busy, 0);
      check_output("post_rst_ready", cmd_ready, 1);
      check_output("post_rst_done", cmd_done, 0);
      repeat (50) @(negedge clock_50);
      check_output("final_queue", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
